// File: rtl/breathe_pkg.sv
// breathe_pkg: key FSM states, default 50 MHz key timing and the mode/run -> led_en lookup
package breathe_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} key_state_t;
  localparam logic [19:0] DEF_CNT_DEBOUNCE_MAX = 20'd999_999;
  localparam logic [25:0] DEF_CNT_LONG_MAX = 26'd49_999_999;
  localparam logic [2:0] LED_EN_STOP = 3'b000;
  localparam logic [2:0] LED_EN_M0 = 3'b111;
  localparam logic [2:0] LED_EN_M1 = 3'b001;
  localparam logic [2:0] LED_EN_M2 = 3'b010;
  localparam logic [2:0] LED_EN_M3 = 3'b100;
  function automatic logic [2:0] led_en_of(input logic [1:0] mode, input logic run);
    return !run ? LED_EN_STOP : mode == 2'd0 ? LED_EN_M0 : mode == 2'd1 ? LED_EN_M1 :
           mode == 2'd2 ? LED_EN_M2 : LED_EN_M3;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF sync + debounce of active-low key_in; outputs key_db (1=released), key_press/key_release pulses
module key_debounce import breathe_pkg::*; #(
  parameter logic [19:0] CNT_DEBOUNCE_MAX = DEF_CNT_DEBOUNCE_MAX
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_db,
  output logic key_press,
  output logic key_release
);
  logic s1, key_s, key_db_d;
  logic [19:0] db_cnt;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      s1 <= 1'b1;
      key_s <= 1'b1;
      key_db <= 1'b1;
      key_db_d <= 1'b1;
      db_cnt <= '0;
    end else begin
      s1 <= key_in;
      key_s <= s1;
      key_db_d <= key_db;
      if (key_s == key_db) db_cnt <= '0;
      else if (db_cnt == CNT_DEBOUNCE_MAX) begin
        key_db <= key_s;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 20'd1;
    end
  assign key_press = key_db_d & ~key_db;
  assign key_release = ~key_db_d & key_db;
endmodule

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: key_in -> short press cycles mode 0..3, long press toggles run_en; outputs led_en, mode, run_en, short_flag, long_flag
module key_mode_ctrl import breathe_pkg::*; #(
  parameter logic [19:0] CNT_DEBOUNCE_MAX = DEF_CNT_DEBOUNCE_MAX,
  parameter logic [25:0] CNT_LONG_MAX = DEF_CNT_LONG_MAX
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic [2:0] led_en,
  output logic [1:0] mode,
  output logic       run_en,
  output logic       short_flag,
  output logic       long_flag
);
  key_state_t state, state_nxt;
  logic [25:0] hold_cnt, hold_nxt;
  logic key_db, key_press, key_release, short_ev, long_ev;
  key_debounce #(.CNT_DEBOUNCE_MAX(CNT_DEBOUNCE_MAX)) u_db (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .key_db(key_db), .key_press(key_press), .key_release(key_release)
  );
  // LONG_HELD leaves on the released level, not the pulse, so a release
  // coinciding with the long threshold cannot strand the FSM there.
  always_comb begin
    state_nxt = state;
    hold_nxt = hold_cnt;
    short_ev = 1'b0;
    long_ev = 1'b0;
    case (state)
      IDLE: if (key_press) begin
        state_nxt = PRESSED;
        hold_nxt = '0;
      end
      PRESSED: if (hold_cnt == CNT_LONG_MAX) begin
        long_ev = 1'b1;
        state_nxt = LONG_HELD;
      end else if (key_release) begin
        short_ev = 1'b1;
        state_nxt = IDLE;
      end else hold_nxt = hold_cnt + 26'd1;
      LONG_HELD: if (key_db) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      hold_cnt <= '0;
      mode <= 2'd0;
      run_en <= 1'b1;
      short_flag <= 1'b0;
      long_flag <= 1'b0;
      led_en <= LED_EN_M0;
    end else begin
      state <= state_nxt;
      hold_cnt <= hold_nxt;
      mode <= mode + {1'b0, short_ev};
      run_en <= run_en ^ long_ev;
      short_flag <= short_ev;
      long_flag <= long_ev;
      led_en <= led_en_of(mode, run_en);
    end
endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb_key_mode_ctrl: randomized + directed key stimulus checked each cycle against a window-based behavioural model
module tb_key_mode_ctrl;
  localparam int LM = 20;
  logic clk = 1'b0, rst_n = 1'b0, key_in = 1'b1;
  logic [2:0] led_en;
  logic [1:0] mode;
  logic run_en, short_flag, long_flag;
  int n_chk = 0, n_pass = 0, n_short = 0, n_long = 0;
  always #5 clk = ~clk;
  key_mode_ctrl #(.CNT_DEBOUNCE_MAX(20'd4), .CNT_LONG_MAX(26'd20)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .key_in(key_in), .led_en(led_en),
    .mode(mode), .run_en(run_en), .short_flag(short_flag), .long_flag(long_flag)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  // model: key level accepted once the synced key has disagreed for 5 straight samples;
  // press timing judged from edge timestamps of the accepted level
  int t, tp, rel_t;
  bit m_s1, m_ks, m_db, in_press, released, sev, lev, all_diff, m_run, m_sf, m_lf;
  bit win [5];
  logic [1:0] m_mode;
  logic [2:0] m_led;
  logic [2:0] tbl [4] = '{3'b111, 3'b001, 3'b010, 3'b100};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t = 0; tp = 0; rel_t = 0;
      m_s1 = 1; m_ks = 1; m_db = 1; in_press = 0; released = 0;
      foreach (win[i]) win[i] = 1;
      m_mode = 0; m_run = 1; m_sf = 0; m_lf = 0; m_led = 3'b111;
    end else begin
      t++;
      m_led = m_run ? tbl[m_mode] : 3'b000;
      sev = released && t == rel_t + 1 && rel_t - tp <= LM;
      lev = in_press && t == tp + LM + 2 && (!released || rel_t > tp + LM);
      m_mode = m_mode + 2'(sev);
      m_run = m_run ^ lev;
      m_sf = sev;
      m_lf = lev;
      for (int i = 4; i > 0; i--) win[i] = win[i-1];
      win[0] = m_ks;
      all_diff = 1;
      foreach (win[i]) if (win[i] == m_db) all_diff = 0;
      if (all_diff) begin
        m_db = ~m_db;
        if (!m_db) begin tp = t; in_press = 1; released = 0; end
        else begin rel_t = t; released = 1; end
      end
      m_ks = m_s1;
      m_s1 = key_in;
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("mode", mode, m_mode);
      chk("run_en", run_en, m_run);
      chk("led_en", led_en, m_led);
      chk("short_flag", short_flag, m_sf);
      chk("long_flag", long_flag, m_lf);
      if (short_flag) n_short++;
      if (long_flag) n_long++;
    end
  task automatic hold(input bit v, input int n);
    key_in = v;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int n;
    bit found;
    logic [2:0] exp_led [4] = '{3'b001, 3'b010, 3'b100, 3'b111};
    repeat (3) @(negedge clk);
    rst_n = 1;
    hold(1, 50);
    chk("rst_mode", mode, 0);
    chk("rst_led", led_en, 7);
    chk("rst_run", run_en, 1);
    chk("rst_flags", n_short + n_long, 0);
    hold(0, 3);
    hold(1, 20);
    chk("glitch_mode", mode, 0);
    chk("glitch_short", n_short, 0);
    for (int i = 0; i < 4; i++) begin
      hold(0, 12);
      hold(1, 25);
      chk("short_mode", mode, (i + 1) % 4);
      chk("short_led", led_en, exp_led[i]);
      chk("short_count", n_short, i + 1);
    end
    hold(0, 40);
    chk("long_while_held", n_long, 1);
    hold(1, 25);
    chk("long_run", run_en, 0);
    chk("long_led", led_en, 0);
    chk("long_no_short", n_short, 4);
    hold(0, 40);
    hold(1, 25);
    chk("long2_run", run_en, 1);
    chk("long2_mode", mode, 0);
    chk("long2_led", led_en, 7);
    for (int i = 0; i < 5; i++) begin
      hold(0, 2);
      hold(1, 2);
    end
    hold(0, 10);
    hold(1, 25);
    chk("bouncy_short", n_short, 5);
    chk("bouncy_mode", mode, 1);
    hold(0, 40);
    hold(1, 25);
    chk("pre_reset_run", run_en, 0);
    hold(0, 18);
    #2 rst_n = 0;
    #1;
    chk("midrst_mode", mode, 0);
    chk("midrst_run", run_en, 1);
    chk("midrst_led", led_en, 7);
    chk("midrst_flags", {short_flag, long_flag}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    found = 0;
    while (!found && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (long_flag) found = 1;
    end
    chk("long_after_reset_cycles", n, 29);
    chk("long_after_reset_run", run_en, 0);
    hold(0, 5);
    hold(1, 30);
    repeat (40) begin
      hold(0, $urandom_range(1, 45));
      hold(1, $urandom_range(1, 45));
    end
    hold(1, 40);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
